// File: rtl/exu_div_ctrl_pkg.sv
// Shared encodings for the execute-stage divide sequencer: op codes, FSM states, bus widths.
package exu_div_ctrl_pkg;

  localparam int REG_BUS_WIDTH  = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'b00,
    DIV_ST_CALC = 2'b01,
    DIV_ST_FIX  = 2'b10,
    DIV_ST_DONE = 2'b11
  } div_state_e;

  function automatic logic is_signed_op(input div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic is_rem_op(input div_op_e op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/exu_div_ctrl_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import exu_div_ctrl_pkg::*;
#(
  parameter int XLEN = REG_BUS_WIDTH
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            msb_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem_i < divisor_i always holds, so the XLEN+1-bit difference never wraps and
  // its top bit is a true sign: set exactly when the trial subtract goes negative.
  always_comb begin
    shifted = {rem_i, msb_i};
    diff    = shifted - {1'b0, divisor_i};
    q_bit_o = ~diff[XLEN];
    rem_o   = q_bit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/exu_div_ctrl.sv
// Multi-cycle RV32M divide sequencer: radix-2 restoring division, one quotient bit per cycle,
// stalling the pipeline while busy and returning quotient/remainder for write-back.
module exu_div_ctrl
  import exu_div_ctrl_pkg::*;
#(
  parameter int XLEN = REG_BUS_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [1:0]                op_i,
  input  logic [XLEN-1:0]           dividend_i,
  input  logic [XLEN-1:0]           divisor_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic                      done_o,
  output logic                      rd_we_o,
  output logic [XLEN-1:0]           rd_data_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o
);

  localparam int CNT_W = $clog2(XLEN);

  div_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  div_op_e                   op_q, op_d;
  logic [XLEN-1:0]           rem_q, rem_d;
  logic [XLEN-1:0]           quo_q, quo_d;
  logic [XLEN-1:0]           dvs_q, dvs_d;
  logic                      q_neg_q, q_neg_d;
  logic                      r_neg_q, r_neg_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]           rd_data_q, rd_data_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic [XLEN-1:0] step_rem;
  logic            step_bit;
  logic            dvd_neg;
  logic            dvs_neg;

  // quo_q doubles as the dividend shift register: its MSB feeds the step,
  // and quotient bits fill in from the LSB.
  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .msb_i     (quo_q[XLEN-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  always_comb begin
    // NOTE: every *_d and output gets its default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    addr_d    = addr_q;
    rd_data_d = rd_data_q;
    rd_addr_d = rd_addr_q;
    stall_o   = 1'b0;

    dvd_neg = is_signed_op(div_op_e'(op_i)) & dividend_i[XLEN-1];
    dvs_neg = is_signed_op(div_op_e'(op_i)) & divisor_i[XLEN-1];

    unique case (state_q)
      DIV_ST_IDLE: begin
        if (start_i && !flush_i) begin
          stall_o = 1'b1;
          op_d    = div_op_e'(op_i);
          addr_d  = rd_addr_i;
          q_neg_d = dvd_neg ^ dvs_neg;
          r_neg_d = dvd_neg;
          quo_d   = dvd_neg ? -dividend_i : dividend_i;
          dvs_d   = dvs_neg ? -divisor_i : divisor_i;
          rem_d   = '0;
          cnt_d   = '0;
          if (divisor_i == '0) begin
            rd_data_d = is_rem_op(div_op_e'(op_i)) ? dividend_i : '1;
            rd_addr_d = rd_addr_i;
            state_d   = DIV_ST_DONE;
          end else begin
            state_d = DIV_ST_CALC;
          end
        end
      end
      DIV_ST_CALC: begin
        stall_o = 1'b1;
        rem_d   = step_rem;
        quo_d   = {quo_q[XLEN-2:0], step_bit};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = DIV_ST_FIX;
      end
      DIV_ST_FIX: begin
        stall_o = 1'b1;
        if (!flush_i) begin
          if (is_rem_op(op_q)) rd_data_d = r_neg_q ? -rem_q : rem_q;
          else                 rd_data_d = q_neg_q ? -quo_q : quo_q;
          rd_addr_d = addr_q;
        end
        state_d = DIV_ST_DONE;
      end
      DIV_ST_DONE: begin
        state_d = DIV_ST_IDLE;
      end
    endcase

    if (flush_i) state_d = DIV_ST_IDLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q   <= DIV_ST_IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // NOTE: working registers carry no reset; IDLE always loads them before CALC/FIX read them.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    rem_q   <= rem_d;
    quo_q   <= quo_d;
    dvs_q   <= dvs_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
    addr_q  <= addr_d;
  end

  assign done_o    = (state_q == DIV_ST_DONE);
  assign rd_we_o   = done_o & ~flush_i;
  assign rd_data_o = rd_data_q;
  assign rd_addr_o = rd_addr_q;

endmodule

// File: tb/tb_exu_div_ctrl.sv
// Self-checking bench for exu_div_ctrl: directed corner cases with literal expectations,
// then randomized traffic compared every cycle against a cycle-count/arithmetic model.
module tb_exu_div_ctrl;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [1:0]        op_i = 2'b00;
  logic [XLEN-1:0]   dividend_i = '0;
  logic [XLEN-1:0]   divisor_i = '0;
  logic [4:0]        rd_addr_i = '0;
  logic              flush_i = 1'b0;
  logic              stall_o;
  logic              done_o;
  logic              rd_we_o;
  logic [XLEN-1:0]   rd_data_o;
  logic [4:0]        rd_addr_o;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  exu_div_ctrl #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .rd_we_o    (rd_we_o),
    .rd_data_o  (rd_data_o),
    .rd_addr_o  (rd_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Architectural result of an RV32M divide, straight from the ISA definition.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return (op[1]) ? a : 32'hFFFF_FFFF;
    if (op == 2'b00 || op == 2'b10) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = a;
      sb = b;
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  // Model state: cycles left before the result cycle, result cycle flag, pending/visible results.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_data = '0;
  logic [4:0]  m_addr = '0;
  logic [31:0] p_res = '0;
  logic [4:0]  p_addr = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_data <= '0;
      m_addr <= '0;
    end else if (flush_i) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 1) begin
      m_left <= m_left - 1;
    end else if (m_left == 1) begin
      m_left <= 0;
      m_done <= 1'b1;
      m_data <= p_res;
      m_addr <= p_addr;
    end else if (start_i) begin
      if (divisor_i == '0) begin
        m_done <= 1'b1;
        m_data <= ref_div(op_i, dividend_i, divisor_i);
        m_addr <= rd_addr_i;
      end else begin
        m_left <= XLEN + 1;
        p_res  <= ref_div(op_i, dividend_i, divisor_i);
        p_addr <= rd_addr_i;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_o",   stall_o,   (m_left > 0) || (!m_done && start_i && !flush_i));
      check("done_o",    done_o,    m_done);
      check("rd_we_o",   rd_we_o,   m_done && !flush_i);
      check("rd_data_o", rd_data_o, m_data);
      check("rd_addr_o", rd_addr_o, m_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op in the current cycle and returns the cycle index of done_o (100 = timeout).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] addr, output int lat, output logic [31:0] res,
                        output logic [4:0] raddr);
    bit seen = 1'b0;
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = addr;
    lat = 0; res = '0; raddr = '0;
    tick();
    start_i = 1'b0;
    while (!seen && lat < 100) begin
      lat++;
      @(negedge clk);
      if (done_o) begin
        seen  = 1'b1;
        res   = rd_data_o;
        raddr = rd_addr_o;
      end
      tick();
    end
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int          lat;
    logic [31:0] res;
    logic [4:0]  raddr;
    run_op(op, a, b, 5'd7, lat, res, raddr);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_res"}, res, exp_res);
  endtask

  task automatic start_divu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] addr);
    start_i = 1'b1; op_i = 2'b01; dividend_i = a; divisor_i = b; rd_addr_i = addr;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    int          lat;
    int          n_done;
    logic [31:0] res;
    logic [4:0]  raddr;

    repeat (2) tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_stall", stall_o, 0);
    check("rst_done", done_o, 0);
    check("rst_data", rd_data_o, 0);
    check("rst_addr", rd_addr_o, 0);
    tick();

    directed("divu_100_7",   2'b01, 32'd100,       32'd7,         34, 32'd14);
    directed("remu_100_7",   2'b11, 32'd100,       32'd7,         34, 32'd2);
    directed("div_m7_2",     2'b00, 32'hFFFF_FFF9, 32'd2,         34, 32'hFFFF_FFFD);
    directed("rem_m7_2",     2'b10, 32'hFFFF_FFF9, 32'd2,         34, 32'hFFFF_FFFF);
    directed("divu_5_0",     2'b01, 32'd5,         32'd0,         1,  32'hFFFF_FFFF);
    directed("rem_5_0",      2'b10, 32'd5,         32'd0,         1,  32'd5);
    directed("div_m5_0",     2'b00, 32'hFFFF_FFFB, 32'd0,         1,  32'hFFFF_FFFF);
    directed("div_ovf",      2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000);
    directed("rem_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0);

    // Flush in cycle 10 with no restart: stall drops in cycle 11, no result ever appears.
    start_divu(32'd1000, 32'd3, 5'd3);
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_stall_low", stall_o, 0);
    n_done = 0;
    repeat (40) begin
      tick();
      @(negedge clk);
      if (done_o) n_done++;
    end
    check("flush_no_done", n_done, 0);
    tick();

    // Flush in cycle 10, restart in cycle 11: done lands in cycle 45.
    start_divu(32'd1000, 32'd3, 5'd3);
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    run_op(2'b01, 32'd12345, 32'd100, 5'd9, lat, res, raddr);
    check("restart_lat", lat, 34);
    check("restart_res", res, 32'd123);
    check("restart_addr", raddr, 5'd9);

    // Reset in cycle 20 of an op: everything zero next cycle and the op never completes.
    start_divu(32'd77, 32'd5, 5'd21);
    repeat (19) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_stall", stall_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_data", rd_data_o, 0);
    check("midrst_addr", rd_addr_o, 0);
    n_done = 0;
    repeat (40) begin
      tick();
      @(negedge clk);
      if (done_o) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    tick();

    // Flush coincident with DONE suppresses the write enable only.
    start_divu(32'd100, 32'd7, 5'd4);
    repeat (33) tick();
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_done_done", done_o, 1);
    check("flush_done_we", rd_we_o, 0);
    tick();
    flush_i = 1'b0;

    repeat (4000) begin
      rst_n   = ($urandom_range(0, 999) != 0);
      flush_i = ($urandom_range(0, 199) == 0);
      start_i = ($urandom_range(0, 3) != 0);
      op_i    = 2'($urandom_range(0, 3));
      rd_addr_i = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0:       dividend_i = 32'h8000_0000;
        1:       dividend_i = 32'hFFFF_FFFF;
        2:       dividend_i = 32'($urandom_range(0, 15));
        default: dividend_i = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       divisor_i = 32'd0;
        1:       divisor_i = 32'hFFFF_FFFF;
        2:       divisor_i = 32'($urandom_range(1, 15));
        3:       divisor_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: divisor_i = $urandom;
      endcase
      tick();
    end
    rst_n = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
